// File: rtl/ipd_pkg.sv
// Shared types and constants for the iterated prisoner's dilemma match controller.
package ipd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DEC,
    ST_SCORE,
    ST_DELAY,
    ST_OVER
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_A    = 2'b01;
  localparam logic [1:0] WINNER_B    = 2'b10;
  localparam logic [1:0] WINNER_TIE  = 2'b11;

  localparam int DEF_PAY_T = 5;
  localparam int DEF_PAY_R = 3;
  localparam int DEF_PAY_P = 1;
  localparam int DEF_PAY_S = 0;

  function automatic logic [1:0] winner_code(input int unsigned score_a, input int unsigned score_b);
    if (score_a > score_b)      return WINNER_A;
    else if (score_b > score_a) return WINNER_B;
    else                        return WINNER_TIE;
  endfunction

endpackage

// File: rtl/ipd_payoff_lut.sv
// Combinational payoff table: maps the two moves (0 = cooperate, 1 = defect) to each side's payoff.
module ipd_payoff_lut
  import ipd_pkg::*;
#(
  parameter int SCORE_W = 8,
  parameter int PAY_T   = DEF_PAY_T,
  parameter int PAY_R   = DEF_PAY_R,
  parameter int PAY_P   = DEF_PAY_P,
  parameter int PAY_S   = DEF_PAY_S
) (
  input  logic               decision_a,
  input  logic               decision_b,
  output logic [SCORE_W-1:0] pay_a,
  output logic [SCORE_W-1:0] pay_b
);

  localparam logic [SCORE_W-1:0] T_W = SCORE_W'(PAY_T);
  localparam logic [SCORE_W-1:0] R_W = SCORE_W'(PAY_R);
  localparam logic [SCORE_W-1:0] P_W = SCORE_W'(PAY_P);
  localparam logic [SCORE_W-1:0] S_W = SCORE_W'(PAY_S);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    pay_a = P_W;
    pay_b = P_W;
    case ({decision_a, decision_b})
      2'b00:   begin pay_a = R_W; pay_b = R_W; end
      2'b01:   begin pay_a = S_W; pay_b = T_W; end
      2'b10:   begin pay_a = T_W; pay_b = S_W; end
      default: begin pay_a = P_W; pay_b = P_W; end
    endcase
  end

endmodule

// File: rtl/ipd_match_controller.sv
// Match controller: sequences MAX_ROUNDS rounds, latches both strategies' moves,
// accumulates saturating scores, paces rounds with a pausable delay and reports the winner.
module ipd_match_controller
  import ipd_pkg::*;
#(
  parameter int MAX_ROUNDS   = 50,
  parameter int ROUND_W      = 7,
  parameter int SCORE_W      = 8,
  parameter int DELAY_CYCLES = 50_000_000,
  parameter int DELAY_W      = 27,
  parameter int PAY_T        = DEF_PAY_T,
  parameter int PAY_R        = DEF_PAY_R,
  parameter int PAY_P        = DEF_PAY_P,
  parameter int PAY_S        = DEF_PAY_S
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               pause,
  input  logic               dec_valid_a,
  input  logic               decision_a,
  input  logic               dec_valid_b,
  input  logic               decision_b,
  output logic               round_start,
  output logic               last_a,
  output logic               last_b,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [ROUND_W-1:0] round_count,
  output logic               game_active,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS - 1);
  localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(DELAY_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_t               state_q;
  logic                 flag_a_q, flag_b_q;
  logic                 move_a_q, move_b_q;
  logic [DELAY_W-1:0]   delay_q;
  logic [SCORE_W-1:0]   score_a_q, score_b_q;
  logic [ROUND_W-1:0]   round_q;
  logic                 last_a_q, last_b_q;
  logic                 round_start_q, game_active_q, game_over_q;
  logic [1:0]           winner_q;

  logic [SCORE_W-1:0]   pay_a, pay_b;
  logic [SCORE_W:0]     sum_a, sum_b;
  logic [SCORE_W-1:0]   score_a_d, score_b_d;
  logic                 got_a, got_b;

  ipd_payoff_lut #(
    .SCORE_W (SCORE_W),
    .PAY_T   (PAY_T),
    .PAY_R   (PAY_R),
    .PAY_P   (PAY_P),
    .PAY_S   (PAY_S)
  ) u_payoff (
    .decision_a (move_a_q),
    .decision_b (move_b_q),
    .pay_a      (pay_a),
    .pay_b      (pay_b)
  );

  // Carry out of the one-bit-wider add means the score would wrap: clamp instead.
  assign sum_a     = {1'b0, score_a_q} + {1'b0, pay_a};
  assign sum_b     = {1'b0, score_b_q} + {1'b0, pay_b};
  assign score_a_d = sum_a[SCORE_W] ? SCORE_MAX : sum_a[SCORE_W-1:0];
  assign score_b_d = sum_b[SCORE_W] ? SCORE_MAX : sum_b[SCORE_W-1:0];

  // A side counts as decided on the very cycle its valid arrives.
  assign got_a = flag_a_q | dec_valid_a;
  assign got_b = flag_b_q | dec_valid_b;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q       <= ST_IDLE;
      flag_a_q      <= 1'b0;
      flag_b_q      <= 1'b0;
      move_a_q      <= 1'b0;
      move_b_q      <= 1'b0;
      delay_q       <= '0;
      score_a_q     <= '0;
      score_b_q     <= '0;
      round_q       <= '0;
      last_a_q      <= 1'b0;
      last_b_q      <= 1'b0;
      round_start_q <= 1'b0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= WINNER_NONE;
    end else begin
      round_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          game_active_q <= 1'b1;
          round_start_q <= 1'b1;
          state_q       <= ST_WAIT_DEC;
        end

        ST_WAIT_DEC: begin
          if (dec_valid_a && !flag_a_q) begin
            flag_a_q <= 1'b1;
            move_a_q <= decision_a;
          end
          if (dec_valid_b && !flag_b_q) begin
            flag_b_q <= 1'b1;
            move_b_q <= decision_b;
          end
          if (got_a && got_b) state_q <= ST_SCORE;
        end

        ST_SCORE: begin
          score_a_q <= score_a_d;
          score_b_q <= score_b_d;
          last_a_q  <= move_a_q;
          last_b_q  <= move_b_q;
          round_q   <= round_q + ROUND_W'(1);
          flag_a_q  <= 1'b0;
          flag_b_q  <= 1'b0;
          if (round_q == LAST_ROUND) begin
            state_q       <= ST_OVER;
            game_active_q <= 1'b0;
            game_over_q   <= 1'b1;
            winner_q      <= winner_code(32'(score_a_d), 32'(score_b_d));
          end else begin
            state_q <= ST_DELAY;
          end
        end

        ST_DELAY: begin
          if (!pause) begin
            if (delay_q == DELAY_LAST) begin
              delay_q       <= '0;
              state_q       <= ST_WAIT_DEC;
              round_start_q <= 1'b1;
            end else begin
              delay_q <= delay_q + DELAY_W'(1);
            end
          end
        end

        ST_OVER: ;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign round_start = round_start_q;
  assign last_a      = last_a_q;
  assign last_b      = last_b_q;
  assign score_a     = score_a_q;
  assign score_b     = score_b_q;
  assign round_count = round_q;
  assign game_active = game_active_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_ipd_match_controller.sv
// Bench for ipd_match_controller: two instances (SCORE_W 8 and 3) share stimulus and are checked
// against a round-level reference model of scores, history, round pacing and winner.
module tb_ipd_match_controller;

  localparam int MAX_R = 3;
  localparam int DLY   = 4;

  logic clk = 1'b0;
  logic reset, restart, pause;
  logic dec_valid_a, decision_a, dec_valid_b, decision_b;

  logic       rs8, la8, lb8, ga8, go8;
  logic [7:0] sa8, sb8;
  logic [6:0] rc8;
  logic [1:0] w8;

  logic       rs3, la3, lb3, ga3, go3;
  logic [2:0] sa3, sb3;
  logic [6:0] rc3;
  logic [1:0] w3;

  always #5 clk = ~clk;

  ipd_match_controller #(
    .MAX_ROUNDS(MAX_R), .ROUND_W(7), .SCORE_W(8), .DELAY_CYCLES(DLY), .DELAY_W(27)
  ) dut8 (
    .clk(clk), .reset(reset), .restart(restart), .pause(pause),
    .dec_valid_a(dec_valid_a), .decision_a(decision_a),
    .dec_valid_b(dec_valid_b), .decision_b(decision_b),
    .round_start(rs8), .last_a(la8), .last_b(lb8), .score_a(sa8), .score_b(sb8),
    .round_count(rc8), .game_active(ga8), .game_over(go8), .winner(w8)
  );

  ipd_match_controller #(
    .MAX_ROUNDS(MAX_R), .ROUND_W(7), .SCORE_W(3), .DELAY_CYCLES(DLY), .DELAY_W(27)
  ) dut3 (
    .clk(clk), .reset(reset), .restart(restart), .pause(pause),
    .dec_valid_a(dec_valid_a), .decision_a(decision_a),
    .dec_valid_b(dec_valid_b), .decision_b(decision_b),
    .round_start(rs3), .last_a(la3), .last_b(lb3), .score_a(sa3), .score_b(sb3),
    .round_count(rc3), .game_active(ga3), .game_over(go3), .winner(w3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one entry per scored round, nothing cycle-level.
  int m_rounds;
  int m_sa8, m_sb8, m_sa3, m_sb3;
  int m_last_a, m_last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Payoff to "me" given both moves (0 = cooperate, 1 = defect): R=3, S=0, T=5, P=1.
  function automatic int pay(input int me, input int other);
    if (me == 0 && other == 0) return 3;
    if (me == 0 && other == 1) return 0;
    if (me == 1 && other == 0) return 5;
    return 1;
  endfunction

  function automatic int sat(input int s, input int p, input int w);
    int lim = (1 << w) - 1;
    return (s + p > lim) ? lim : s + p;
  endfunction

  function automatic int win(input int a, input int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  task automatic model_clear();
    m_rounds = 0;
    m_sa8 = 0; m_sb8 = 0; m_sa3 = 0; m_sb3 = 0;
    m_last_a = 0; m_last_b = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_sa8"}, sa8, m_sa8);
    check({tag, "_sb8"}, sb8, m_sb8);
    check({tag, "_sa3"}, sa3, m_sa3);
    check({tag, "_sb3"}, sb3, m_sb3);
    check({tag, "_rc8"}, rc8, m_rounds);
    check({tag, "_rc3"}, rc3, m_rounds);
    check({tag, "_la8"}, la8, m_last_a);
    check({tag, "_lb8"}, lb8, m_last_b);
    check({tag, "_la3"}, la3, m_last_a);
    check({tag, "_lb3"}, lb3, m_last_b);
  endtask

  task automatic wait_round_start(input string tag);
    int n = 0;
    while (rs8 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rs8_seen"}, rs8, 1);
    check({tag, "_rs3_seen"}, rs3, 1);
  endtask

  // One round: each side's first valid comes da/db cycles after round_start; afterwards the
  // valid stays high with the opposite move, which must be ignored. pl = paused DELAY cycles.
  task automatic play_round(input int mv_a, input int mv_b, input int da, input int db,
                            input int pl, input string tag);
    int m, cnt;
    wait_round_start(tag);
    check({tag, "_ga8"}, ga8, 1);
    check({tag, "_ga3"}, ga3, 1);
    check({tag, "_go8"}, go8, 0);
    m = (da > db) ? da : db;
    for (int k = 0; k <= m; k++) begin
      if (k == 1) check({tag, "_rs_pulse"}, rs8, 0);
      if (k > 0) begin
        check({tag, "_wait_rc"}, rc8, m_rounds);
        check({tag, "_wait_sa"}, sa8, m_sa8);
      end
      dec_valid_a = (k >= da);
      decision_a  = (k == da) ? mv_a[0] : ~mv_a[0];
      dec_valid_b = (k >= db);
      decision_b  = (k == db) ? mv_b[0] : ~mv_b[0];
      pause       = 1'($urandom);
      @(negedge clk);
    end
    dec_valid_a = 1'b0;
    dec_valid_b = 1'b0;
    check({tag, "_score_cyc_rc"}, rc8, m_rounds);
    @(negedge clk);
    m_rounds++;
    m_sa8 = sat(m_sa8, pay(mv_a, mv_b), 8);
    m_sb8 = sat(m_sb8, pay(mv_b, mv_a), 8);
    m_sa3 = sat(m_sa3, pay(mv_a, mv_b), 3);
    m_sb3 = sat(m_sb3, pay(mv_b, mv_a), 3);
    m_last_a = mv_a;
    m_last_b = mv_b;
    check_state(tag);
    if (m_rounds == MAX_R) begin
      check({tag, "_over8"}, go8, 1);
      check({tag, "_over3"}, go3, 1);
      check({tag, "_active_off"}, ga8, 0);
      check({tag, "_win8"}, w8, win(m_sa8, m_sb8));
      check({tag, "_win3"}, w3, win(m_sa3, m_sb3));
    end else begin
      check({tag, "_not_over"}, go8, 0);
      cnt = 0;
      while (rs8 !== 1'b1 && cnt < 200) begin
        pause = (cnt >= 1 && cnt <= pl);
        if (pause) begin
          check({tag, "_pause_rc"}, rc8, m_rounds);
          check({tag, "_pause_sa"}, sa8, m_sa8);
        end
        @(negedge clk);
        cnt++;
      end
      pause = 1'b0;
      check({tag, "_delay_len"}, cnt, DLY + pl);
    end
  endtask

  task automatic hold_over(input string tag);
    pause = 1'b0;
    repeat (5) begin
      dec_valid_a = 1'b1; decision_a = 1'($urandom);
      dec_valid_b = 1'b1; decision_b = 1'($urandom);
      @(negedge clk);
      check({tag, "_no_rs"}, rs8, 0);
      check({tag, "_held_go"}, go8, 1);
      check({tag, "_held_rc"}, rc8, MAX_R);
    end
    dec_valid_a = 1'b0;
    dec_valid_b = 1'b0;
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    @(negedge clk);
    model_clear();
    check({tag, "_go"}, go8, 0);
    check({tag, "_win"}, w8, 0);
    check({tag, "_rs"}, rs8, 0);
    check_state(tag);
    restart = 1'b0;
  endtask

  task automatic random_match(input string tag);
    for (int r = 0; r < MAX_R; r++)
      play_round(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), tag);
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; pause = 1'b0;
    dec_valid_a = 1'b0; decision_a = 1'b0;
    dec_valid_b = 1'b0; decision_b = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_rs", rs8, 0);
    check("reset_ga", ga8, 0);
    check("reset_go", go8, 0);
    check("reset_win", w8, 0);
    check("reset_go3", go3, 0);
    check_state("reset");
    reset = 1'b0;

    // Mutual cooperation: 3,6,9 and a tie.
    for (int r = 0; r < MAX_R; r++) play_round(0, 0, 0, 0, 0, "cc");
    check("cc_final_a", sa8, 9);
    check("cc_final_win", w8, 3);
    hold_over("cc_over");

    // A defects early, B cooperates late; then a 10-cycle pause in DELAY.
    do_restart("rst1");
    play_round(1, 0, 2, 5, 10, "dc_late");
    play_round(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 0, "m2r2");
    play_round(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 0, "m2r3");
    hold_over("m2_over");

    repeat (3) begin
      do_restart("rst_rand");
      random_match("rand");
      hold_over("rand_over");
    end

    // Restart in WAIT_DEC with only A latched: the next round needs a fresh A decision.
    do_restart("rst_mid");
    play_round(1, 1, 0, 0, 0, "pre_mid");
    wait_round_start("mid");
    dec_valid_a = 1'b1; decision_a = 1'b1;
    @(negedge clk);
    dec_valid_a = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    model_clear();
    check("mid_ga", ga8, 0);
    check("mid_rs", rs8, 0);
    check_state("mid_cleared");
    restart = 1'b0;
    play_round(0, 1, 8, 0, 0, "fresh_a");
    play_round(1, 1, 1, 0, 0, "fresh_r2");
    play_round(0, 0, 0, 3, 0, "fresh_r3");
    hold_over("fresh_over");

    // Saturation on the 3-bit instance: 5 then 7, A wins.
    do_restart("rst_sat");
    for (int r = 0; r < MAX_R; r++) play_round(1, 0, 0, 0, 0, "sat");
    check("sat_a3", sa3, 7);
    check("sat_win3", w3, 1);

    // Reset and restart together in OVER.
    reset = 1'b1; restart = 1'b1;
    @(negedge clk);
    model_clear();
    check("rr_go", go8, 0);
    check("rr_win", w8, 0);
    check("rr_win3", w3, 0);
    check("rr_ga", ga8, 0);
    check("rr_rs", rs8, 0);
    check_state("rr");
    reset = 1'b0; restart = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
